// File: rtl/step_ctrl_pkg.sv
// Shared opcodes and FSM state encoding for the programmable step controller.
package step_ctrl_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD_IMM = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB_IMM = 3'd2;
    localparam logic [OP_W-1:0] OP_MUL2    = 3'd3;
    localparam logic [OP_W-1:0] OP_ADD_IN  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR_IMM = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Program entry with the immediate at a fixed 8-bit width.
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [7:0]      imm;
    } prog_entry8_t;

endpackage

// File: rtl/step_controller_prog_alu.sv
// One program step: WIDTH+1 bit arithmetic with wrap or saturate.
module step_alu
    import step_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic [WIDTH-1:0] orig_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);

    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] sat_val;

    always_comb begin
        wide = {1'b0, acc_i};
        case (op_i)
            OP_ADD_IMM: wide = {1'b0, acc_i} + {1'b0, imm_i};
            OP_SUB_IMM: wide = {1'b0, acc_i} - {1'b0, imm_i};
            OP_MUL2:    wide = {acc_i, 1'b0};
            OP_ADD_IN:  wide = {1'b0, acc_i} + {1'b0, orig_i};
            OP_XOR_IMM: wide = {1'b0, acc_i ^ imm_i};
            default:    wide = {1'b0, acc_i};
        endcase
        // Bit WIDTH is carry-out for add/shift and borrow for subtract.
        ovf_o    = wide[WIDTH];
        sat_val  = (op_i == OP_SUB_IMM) ? '0 : '1;
        result_o = (ovf_o && sat_i) ? sat_val : wide[WIDTH-1:0];
    end

endmodule

// File: rtl/step_controller_prog.sv
// Programmable multi-step controller: runs a register-held op/imm program
// over a captured operand and returns the result with a done pulse.
module step_controller_prog
    import step_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_STEPS = 8,
    parameter int AW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW:0]      step_cnt,
    input  logic             sat_mode,
    input  logic             abort,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [OP_W-1:0]  prog_op,
    input  logic [WIDTH-1:0] prog_imm,
    output logic [WIDTH-1:0] data_out,
    output logic             done,
    output logic             busy,
    output logic             overflow,
    output logic             aborted,
    output logic             prog_err
);

    localparam logic [AW:0] MAX_N = (AW+1)'(NUM_STEPS);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] imm;
    } prog_entry_t;

    prog_entry_t      prog_q [NUM_STEPS];
    prog_entry_t      cur;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, orig_q, orig_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [AW:0]      idx_q, idx_d, n_q, n_d, cnt_clamped;
    logic             sat_q, sat_d, ovf_q, ovf_d;
    logic             overflow_q, overflow_d;
    logic             aborted_q, aborted_d, prog_err_q, prog_err_d;
    logic             prog_wr_ok;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign cnt_clamped = (step_cnt > MAX_N) ? MAX_N : step_cnt;
    assign cur         = prog_q[idx_q[AW-1:0]];
    assign prog_wr_ok  = prog_we && (state_q == S_IDLE)
                         && ({1'b0, prog_addr} < MAX_N);

    step_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i     (cur.op),
        .acc_i    (acc_q),
        .imm_i    (cur.imm),
        .orig_i   (orig_q),
        .sat_i    (sat_q),
        .result_o (alu_res),
        .ovf_o    (alu_ovf)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        orig_d     = orig_q;
        idx_d      = idx_q;
        n_d        = n_q;
        sat_d      = sat_q;
        ovf_d      = ovf_q;
        data_out_d = data_out_q;
        overflow_d = overflow_q;
        aborted_d  = 1'b0;
        prog_err_d = prog_we && (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d  = data_in;
                    orig_d = data_in;
                    n_d    = cnt_clamped;
                    sat_d  = sat_mode;
                    idx_d  = '0;
                    ovf_d  = 1'b0;
                    if (cnt_clamped == '0) begin
                        state_d    = S_DONE;
                        data_out_d = data_in;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    acc_d = alu_res;
                    ovf_d = ovf_q | alu_ovf;
                    idx_d = idx_q + 1'b1;
                    // Result registers load on the edge that enters DONE.
                    if ((idx_q + 1'b1) == n_q) begin
                        state_d    = S_DONE;
                        data_out_d = alu_res;
                        overflow_d = ovf_q | alu_ovf;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            orig_q     <= '0;
            idx_q      <= '0;
            n_q        <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
            aborted_q  <= 1'b0;
            prog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            orig_q     <= orig_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
            data_out_q <= data_out_d;
            overflow_q <= overflow_d;
            aborted_q  <= aborted_d;
            prog_err_q <= prog_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                prog_q[i] <= '{op: OP_NOP, imm: '0};
            end
        end else if (prog_wr_ok) begin
            prog_q[prog_addr] <= '{op: prog_op, imm: prog_imm};
        end
    end

    assign data_out = data_out_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE);
    assign overflow = overflow_q;
    assign aborted  = aborted_q;
    assign prog_err = prog_err_q;

endmodule

// File: tb/tb_step_controller_prog.sv
// Bench for step_controller_prog: directed vectors, corner sequences and
// randomized programs checked against an arithmetic reference model.
module tb_step_controller_prog;

    localparam int W    = 8;
    localparam int NS   = 8;
    localparam int AW   = 3;
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [AW:0]   step_cnt = '0;
    logic          sat_mode = 1'b0;
    logic          abort = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [2:0]    prog_op = '0;
    logic [W-1:0]  prog_imm = '0;
    logic [W-1:0]  data_out;
    logic          done, busy, overflow, aborted, prog_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_op  [NS];
    int m_imm [NS];

    typedef struct {
        logic [2:0] op;
        logic [7:0] imm;
        logic [7:0] din;
        bit         sat;
        logic [7:0] exp_out;
        bit         exp_ovf;
    } vec_t;

    vec_t vecs [15];

    step_controller_prog #(.WIDTH(W), .NUM_STEPS(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_in   (data_in),
        .step_cnt  (step_cnt),
        .sat_mode  (sat_mode),
        .abort     (abort),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_op   (prog_op),
        .prog_imm  (prog_imm),
        .data_out  (data_out),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow),
        .aborted   (aborted),
        .prog_err  (prog_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input int din, input int cnt,
                                  input bit sat, output int res,
                                  output bit ovf);
        int n, acc, t;
        n = (cnt > NS) ? NS : cnt;
        acc = din;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (m_op[i])
                1:       t = acc + m_imm[i];
                2:       t = acc - m_imm[i];
                3:       t = acc * 2;
                4:       t = acc + din;
                5:       t = acc ^ m_imm[i];
                default: t = acc;
            endcase
            if (t > MAXV) begin
                ovf = 1'b1;
                t = sat ? MAXV : t - (MAXV + 1);
            end else if (t < 0) begin
                ovf = 1'b1;
                t = sat ? 0 : t + MAXV + 1;
            end
            acc = t;
        end
        res = acc;
    endfunction

    task automatic write_prog(input int addr, input int op, input int imm);
        prog_we   = 1'b1;
        prog_addr = addr[AW-1:0];
        prog_op   = op[2:0];
        prog_imm  = imm[W-1:0];
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        m_op[addr]  = op;
        m_imm[addr] = imm;
    endtask

    task automatic do_start(input int din, input int cnt, input bit sat);
        data_in  = din[W-1:0];
        step_cnt = cnt[AW:0];
        sat_mode = sat;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done(input string name);
        int g;
        g = 0;
        while (done !== 1'b1 && g < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            g++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=%0b expected 1", name, done);
        end
    endtask

    task automatic run_op(input string name, input int din, input int cnt,
                          input bit sat, input int eo, input bit ev,
                          input int el);
        do_start(din, cnt, sat);
        wait_done(name);
        chk({name, "_lat"}, cyc, el);
        chk({name, "_out"}, data_out, eo);
        chk({name, "_ovf"}, overflow, ev);
        @(posedge clk);
        #1;
        chk({name, "_idle"}, {done, busy}, 0);
    endtask

    initial begin
        int er, lat, d, c;
        bit eo, s;

        vecs[0]  = '{3'd1, 8'd5,   8'd10,  1'b0, 8'd15,  1'b0};
        vecs[1]  = '{3'd1, 8'd250, 8'd10,  1'b0, 8'd4,   1'b1};
        vecs[2]  = '{3'd1, 8'd250, 8'd10,  1'b1, 8'd255, 1'b1};
        vecs[3]  = '{3'd2, 8'd20,  8'd10,  1'b0, 8'd246, 1'b1};
        vecs[4]  = '{3'd2, 8'd20,  8'd10,  1'b1, 8'd0,   1'b1};
        vecs[5]  = '{3'd2, 8'd3,   8'd10,  1'b1, 8'd7,   1'b0};
        vecs[6]  = '{3'd3, 8'd0,   8'h90,  1'b0, 8'h20,  1'b1};
        vecs[7]  = '{3'd3, 8'd0,   8'h90,  1'b1, 8'hFF,  1'b1};
        vecs[8]  = '{3'd3, 8'd0,   8'h30,  1'b1, 8'h60,  1'b0};
        vecs[9]  = '{3'd4, 8'd0,   8'h90,  1'b0, 8'h20,  1'b1};
        vecs[10] = '{3'd4, 8'd0,   8'h90,  1'b1, 8'hFF,  1'b1};
        vecs[11] = '{3'd5, 8'hFF,  8'h0F,  1'b1, 8'hF0,  1'b0};
        vecs[12] = '{3'd6, 8'h11,  8'h33,  1'b1, 8'h33,  1'b0};
        vecs[13] = '{3'd7, 8'h22,  8'h44,  1'b0, 8'h44,  1'b0};
        vecs[14] = '{3'd0, 8'h99,  8'h12,  1'b1, 8'h12,  1'b0};
        for (int i = 0; i < NS; i++) begin
            m_op[i]  = 0;
            m_imm[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {data_out, done, busy, overflow, aborted, prog_err}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        write_prog(0, 1, 5);
        write_prog(1, 3, 0);
        write_prog(2, 1, 3);
        write_prog(3, 1, 3);
        write_prog(4, 4, 0);
        run_op("progA", 10, 5, 1'b0, 46, 1'b0, 6);

        do_start(20, 5, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_pulse", aborted, 1);
        chk("abort_nodone", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_keep_out", data_out, 46);
        chk("abort_keep_ovf", overflow, 0);
        @(posedge clk);
        #1;
        chk("abort_pulse_end", {aborted, done, busy}, 0);
        run_op("after_abort", 1, 5, 1'b0, 19, 1'b0, 6);

        do_start(10, 5, 1'b0);
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_op   = 3'd5;
        prog_imm  = 8'hFF;
        @(posedge clk);
        #1;
        cyc++;
        start   = 1'b0;
        prog_we = 1'b0;
        chk("busy_prog_err", prog_err, 1);
        wait_done("busy_wr");
        chk("busy_wr_lat", cyc, 6);
        chk("busy_wr_out", data_out, 46);
        @(posedge clk);
        #1;
        chk("busy_err_end", prog_err, 0);
        @(posedge clk);
        #1;
        chk("busy_start_dropped", busy, 0);

        write_prog(0, 1, 200);
        write_prog(1, 1, 100);
        run_op("ovf_wrap", 10, 2, 1'b0, 54, 1'b1, 3);
        run_op("ovf_sat", 10, 2, 1'b1, 255, 1'b1, 3);
        write_prog(0, 2, 20);
        run_op("sub_sat", 10, 1, 1'b1, 0, 1'b1, 2);
        run_op("zero_steps", 8'h5A, 0, 1'b0, 8'h5A, 1'b0, 1);

        for (int i = 0; i < NS; i++) write_prog(i, 1, 1);
        run_op("clamp", 0, NS + 3, 1'b0, NS, 1'b0, NS + 1);
        run_op("clamp_max", 3, 15, 1'b0, NS + 3, 1'b0, NS + 1);

        data_in  = 8'd5;
        step_cnt = 4'd3;
        sat_mode = 1'b0;
        start    = 1'b1;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        cyc   = 1;
        chk("start_abort_busy", {busy, aborted}, 2'b10);
        wait_done("start_abort");
        chk("start_abort_lat", cyc, 4);
        chk("start_abort_out", data_out, 8);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_in_done", {aborted, busy}, 0);

        prog_we   = 1'b1;
        prog_addr = '0;
        prog_op   = 3'd1;
        prog_imm  = 8'd7;
        data_in   = 8'd1;
        step_cnt  = 4'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        cyc     = 1;
        m_op[0]  = 1;
        m_imm[0] = 7;
        wait_done("wr_start");
        chk("wr_start_out", data_out, 8);
        chk("wr_start_lat", cyc, 2);
        @(posedge clk);
        #1;

        for (int i = 0; i < NS; i++) vecs[0].sat = vecs[0].sat;
        foreach (vecs[i]) begin
            write_prog(0, int'(vecs[i].op), int'(vecs[i].imm));
            run_op($sformatf("vec%0d", i), int'(vecs[i].din), 1,
                   vecs[i].sat, int'(vecs[i].exp_out), vecs[i].exp_ovf, 2);
        end

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 3)) begin
                write_prog($urandom_range(0, NS - 1), $urandom_range(0, 7),
                           $urandom_range(0, MAXV));
            end
            d = $urandom_range(0, MAXV);
            c = $urandom_range(0, 15);
            s = 1'($urandom_range(0, 1));
            model(d, c, s, er, eo);
            lat = ((c > NS) ? NS : c) + 1;
            run_op($sformatf("rnd%0d", it), d, c, s, er, eo, lat);
        end

        write_prog(0, 1, 250);
        run_op("pre_rst", 10, 1, 1'b0, 4, 1'b1, 2);
        do_start(10, 5, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", {data_out, done, busy, overflow, aborted, prog_err}, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            m_op[i]  = 0;
            m_imm[i] = 0;
        end
        model(10, 5, 1'b0, er, eo);
        run_op("post_rst", 10, 5, 1'b0, er, eo, 6);
        chk("post_rst_nop", data_out, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
